// File: rtl/p_emap_pack_8.sv
// p_emap_pack_8: packs index-tagged scalar elements into no_of_units-wide gather-memory lines.
// Define P_EMAP_PACK_WMASK_EN to add a write_mask output (MS bit = lane 0) for lane-merging memories.
module p_emap_pack_8 #(
    parameter int                       no_of_units   = 8,
    parameter int                       element_width = 64,
    parameter int                       address_width = 32,
    parameter logic [address_width-1:0] base_address  = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [address_width-1:0]             in_index,
    input  logic [element_width-1:0]             in_data,
    input  logic                                 flush,
    output logic                                 write_enable,
    output logic [address_width-1:0]             write_address,
    output logic [no_of_units*element_width-1:0] input_data,
`ifdef P_EMAP_PACK_WMASK_EN
    output logic [no_of_units-1:0]               write_mask,
`endif
    output logic                                 flush_done,
    output logic [31:0]                          lines_written
);

    localparam int LW = (no_of_units > 1) ? $clog2(no_of_units) : 1;
    localparam int DW = no_of_units * element_width;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

    state_t                   r_state, w_stateNext;
    logic [DW-1:0]            r_buf, w_nextBuf;
    logic [no_of_units-1:0]   r_mask, w_nextMask;
    logic [address_width-1:0] r_line, w_nextLine;
    logic                     r_inReady;
    logic                     r_flushDone, w_doneNext;
    logic                     r_we;
    logic [address_width-1:0] r_addr;
    logic [DW-1:0]            r_data;
    logic [31:0]              r_lines;
`ifdef P_EMAP_PACK_WMASK_EN
    logic [no_of_units-1:0]   r_wmask;
`endif

    logic                     w_accept, w_idxValid, w_flushReq;
    logic [address_width-1:0] w_line;
    logic [LW-1:0]            w_lane;
    logic [DW-1:0]            w_placed, w_merged, w_keep;
    logic [no_of_units-1:0]   w_laneBit, w_mergedMask;
    logic                     w_wr;
    logic [DW-1:0]            w_wrData;
    logic [no_of_units-1:0]   w_wrMask;
    logic [address_width-1:0] w_wrLine;

    assign w_accept   = in_valid && r_inReady;
    assign w_idxValid = (in_index != '1);
    assign w_line     = in_index / address_width'(no_of_units);
    assign w_lane     = LW'(in_index % address_width'(no_of_units));
    assign w_flushReq = (r_state != FLUSH) ? flush : !r_flushDone;

    // Lane 0 is the MS slice of a line (and the MS bit of a lane mask), matching the gather side.
    always_comb begin
        w_placed  = '0;
        w_merged  = r_buf;
        w_laneBit = '0;
        for (int k = 0; k < no_of_units; k++) begin
            if (int'(w_lane) == k) begin
                w_placed[(no_of_units-k)*element_width-1 -: element_width] = in_data;
                w_merged[(no_of_units-k)*element_width-1 -: element_width] = in_data;
                w_laneBit[no_of_units-1-k] = 1'b1;
            end
        end
        w_mergedMask = r_mask | w_laneBit;
    end

    always_comb begin
        w_nextBuf   = r_buf;
        w_nextMask  = r_mask;
        w_nextLine  = r_line;
        w_wr        = 1'b0;
        w_wrData    = r_buf;
        w_wrMask    = r_mask;
        w_wrLine    = r_line;
        w_stateNext = r_state;
        w_doneNext  = 1'b0;

        if (w_accept && w_idxValid) begin
            if (r_mask != '0 && w_line != r_line) begin
                w_wr       = 1'b1;
                w_nextBuf  = w_placed;
                w_nextMask = w_laneBit;
                w_nextLine = w_line;
            end else if (w_mergedMask == '1) begin
                w_wr       = 1'b1;
                w_wrData   = w_merged;
                w_wrMask   = '1;
                w_wrLine   = w_line;
                w_nextBuf  = '0;
                w_nextMask = '0;
            end else begin
                w_nextBuf  = w_merged;
                w_nextMask = w_mergedMask;
                w_nextLine = w_line;
            end
        end

        // A flush keeps draining one line per cycle; done is only raised on a cycle with no write.
        if (w_flushReq) begin
            w_stateNext = FLUSH;
            if (w_nextMask != '0) begin
                if (!w_wr) begin
                    w_wr       = 1'b1;
                    w_wrData   = w_nextBuf;
                    w_wrMask   = w_nextMask;
                    w_wrLine   = w_nextLine;
                    w_nextBuf  = '0;
                    w_nextMask = '0;
                end
            end else if (!w_wr) begin
                w_doneNext = 1'b1;
            end
        end else if (r_state == FLUSH) begin
            w_stateNext = IDLE;
        end else if (w_accept) begin
            w_stateNext = FILL;
        end
    end

    always_comb begin
        w_keep = '0;
        for (int k = 0; k < no_of_units; k++) begin
            w_keep[(no_of_units-k)*element_width-1 -: element_width] = {element_width{w_wrMask[no_of_units-1-k]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_buf       <= '0;
            r_mask      <= '0;
            r_line      <= '0;
            r_inReady   <= 1'b0;
            r_flushDone <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_lines     <= '0;
`ifdef P_EMAP_PACK_WMASK_EN
            r_wmask     <= '0;
`endif
        end else begin
            r_state     <= w_stateNext;
            r_buf       <= w_nextBuf;
            r_mask      <= w_nextMask;
            r_line      <= w_nextLine;
            r_inReady   <= (w_stateNext != FLUSH);
            r_flushDone <= w_doneNext;
            r_we        <= w_wr;
            if (w_wr) begin
                r_addr  <= base_address + w_wrLine;
                r_data  <= w_wrData & w_keep;
`ifdef P_EMAP_PACK_WMASK_EN
                r_wmask <= w_wrMask;
`endif
            end
            if (r_flushDone) begin
                r_lines <= '0;
            end else if (w_wr) begin
                r_lines <= r_lines + 32'd1;
            end
        end
    end

    assign in_ready      = r_inReady;
    assign write_enable  = r_we;
    assign write_address = r_addr;
    assign input_data    = r_data;
    assign flush_done    = r_flushDone;
    assign lines_written = r_lines;
`ifdef P_EMAP_PACK_WMASK_EN
    assign write_mask    = r_wmask;
`endif

endmodule

// File: tb/tb_p_emap_pack_8.sv
// tb_p_emap_pack_8: directed and random stimulus against a queue-based line-packing model.
// Two instances (base_address 0 and 100) see identical inputs.
module tb_p_emap_pack_8;

    localparam int BASE_B = 100;

    typedef struct {
        logic [31:0]  line;
        logic [511:0] data;
        logic [7:0]   mask;
    } rec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [31:0]  in_index;
    logic [63:0]  in_data;
    logic         flush;

    logic         rdyA, weA, doneA, rdyB, weB, doneB;
    logic [31:0]  addrA, addrB, linesA, linesB;
    logic [511:0] dataA, dataB;
`ifdef P_EMAP_PACK_WMASK_EN
    logic [7:0]   maskA, maskB;
`endif

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: pending lane contents plus a queue of lines waiting to be written.
    bit           mHas[8];
    logic [63:0]  mVal[8];
    logic [31:0]  mLine;
    bit           mInFlush;
    rec_t         q[$];

    bit           eWe, eDone, eReady;
    logic [31:0]  eLine;
    logic [511:0] eData;
    logic [7:0]   eMask;
    int           eLines;

    p_emap_pack_8 #(.no_of_units(8), .element_width(64), .address_width(32), .base_address(32'd0)) u_dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyA), .in_index(in_index),
        .in_data(in_data), .flush(flush), .write_enable(weA), .write_address(addrA), .input_data(dataA),
`ifdef P_EMAP_PACK_WMASK_EN
        .write_mask(maskA),
`endif
        .flush_done(doneA), .lines_written(linesA)
    );

    p_emap_pack_8 #(.no_of_units(8), .element_width(64), .address_width(32), .base_address(32'(BASE_B))) u_dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyB), .in_index(in_index),
        .in_data(in_data), .flush(flush), .write_enable(weB), .write_address(addrB), .input_data(dataB),
`ifdef P_EMAP_PACK_WMASK_EN
        .write_mask(maskB),
`endif
        .flush_done(doneB), .lines_written(linesB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit anyHas();
        bit r = 1'b0;
        for (int k = 0; k < 8; k++) r |= mHas[k];
        return r;
    endfunction

    function automatic bit allHas();
        bit r = 1'b1;
        for (int k = 0; k < 8; k++) r &= mHas[k];
        return r;
    endfunction

    function automatic void pushBuf();
        rec_t r;
        r.line = mLine;
        r.data = '0;
        r.mask = '0;
        for (int k = 0; k < 8; k++) begin
            if (mHas[k]) begin
                r.data[(7-k)*64 +: 64] = mVal[k];
                r.mask[7-k] = 1'b1;
            end
            mHas[k] = 1'b0;
            mVal[k] = '0;
        end
        q.push_back(r);
    endfunction

    task automatic checkCycle();
        checkOutput("weA", 512'(weA), 512'(eWe));
        checkOutput("weB", 512'(weB), 512'(eWe));
        if (eWe) begin
            checkOutput("addrA", 512'(addrA), 512'(eLine));
            checkOutput("addrB", 512'(addrB), 512'(32'(eLine + 32'(BASE_B))));
            checkOutput("dataA", dataA, eData);
            checkOutput("dataB", dataB, eData);
`ifdef P_EMAP_PACK_WMASK_EN
            checkOutput("maskA", 512'(maskA), 512'(eMask));
            checkOutput("maskB", 512'(maskB), 512'(eMask));
`endif
        end
        checkOutput("doneA", 512'(doneA), 512'(eDone));
        checkOutput("doneB", 512'(doneB), 512'(eDone));
        checkOutput("readyA", 512'(rdyA), 512'(eReady));
        checkOutput("readyB", 512'(rdyB), 512'(eReady));
        checkOutput("linesA", 512'(linesA), 512'(32'(eLines)));
        checkOutput("linesB", 512'(linesB), 512'(32'(eLines)));
    endtask

    task automatic applyReset(input int nCycles);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_index = '0;
        in_data  = '0;
        flush    = 1'b0;
        repeat (nCycles) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            mHas[k] = 1'b0;
            mVal[k] = '0;
        end
        mLine    = '0;
        mInFlush = 1'b0;
        q.delete();
        eWe = 1'b0; eDone = 1'b0; eReady = 1'b0;
        eLine = '0; eData = '0; eMask = '0; eLines = 0;
        checkCycle();
        checkOutput("rstAddrA", 512'(addrA), 512'(0));
        checkOutput("rstAddrB", 512'(addrB), 512'(0));
        checkOutput("rstDataA", dataA, '0);
        checkOutput("rstDataB", dataB, '0);
        rst_n = 1'b1;
    endtask

    // Checks the current cycle, drives one cycle of inputs and advances the model to the next cycle.
    task automatic applyStimulus(input bit v, input logic [31:0] idx, input logic [63:0] d, input bit f);
        bit          acc, popped, nDone;
        rec_t        r;
        logic [31:0] ln;
        int          lane;
        checkCycle();
        in_valid = v;
        in_index = idx;
        in_data  = d;
        flush    = f;
        acc = v && eReady;
        if (acc && idx != 32'hFFFF_FFFF) begin
            ln   = idx / 32'd8;
            lane = int'(idx % 32'd8);
            if (anyHas() && ln != mLine) pushBuf();
            mHas[lane] = 1'b1;
            mVal[lane] = d;
            mLine      = ln;
            if (allHas()) pushBuf();
        end
        if (f && !mInFlush) begin
            mInFlush = 1'b1;
            if (anyHas()) pushBuf();
        end
        popped = 1'b0;
        eWe    = 1'b0;
        if (q.size() > 0) begin
            r      = q.pop_front();
            eWe    = 1'b1;
            eLine  = r.line;
            eData  = r.data;
            eMask  = r.mask;
            popped = 1'b1;
        end
        nDone  = mInFlush && !eDone && !popped && (q.size() == 0);
        eLines = eDone ? 0 : eLines + (popped ? 1 : 0);
        if (eDone) mInFlush = 1'b0;
        eDone  = nDone;
        eReady = !mInFlush;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 32'h0, 64'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] idx;
        logic [63:0] d;
        int          seqIdx;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_index = '0;
        in_data  = '0;
        flush    = 1'b0;
        applyReset(2);
        idle(2);

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'(i), 64'h10 + 64'(i), 1'b0);
        idle(2);

        applyStimulus(1'b1, 32'd8, 64'hAAAA_0008, 1'b0);
        applyStimulus(1'b1, 32'd9, 64'hAAAA_0009, 1'b0);
        applyStimulus(1'b1, 32'd24, 64'hAAAA_0024, 1'b0);
        idle(1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1);
        idle(3);

        applyStimulus(1'b1, 32'hFFFF_FFFF, 64'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b1, 32'd5, 64'h0000_000A, 1'b0);
        applyStimulus(1'b1, 32'd5, 64'h0000_000B, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1);
        idle(3);

        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1);
        idle(2);

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i), 64'h100 + 64'(i), 1'b0);
        applyReset(1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1);
        idle(3);

        // Flush together with the accept that completes a line, and together with a line change.
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'(16 + i), 64'h200 + 64'(i), 1'b0);
        applyStimulus(1'b1, 32'd23, 64'h207, 1'b1);
        idle(3);
        applyStimulus(1'b1, 32'd40, 64'h300, 1'b0);
        applyStimulus(1'b1, 32'd50, 64'h301, 1'b1);
        applyStimulus(1'b1, 32'd51, 64'h302, 1'b1);
        idle(4);

        seqIdx = 0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                idx    = 32'(seqIdx);
                seqIdx = (seqIdx + 1) % 64;
            end else begin
                idx = 32'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 19) == 0) idx = 32'hFFFF_FFFF;
            d = {$urandom(), $urandom()};
            if ($urandom_range(0, 299) == 0) begin
                applyReset(1);
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, idx, d, $urandom_range(0, 15) == 0);
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
